// File: rtl/data_memory_responder.sv
// Word-addressed data memory responding to MemRead/MemWrite strobes with programmable
// wait states, request validation and a registered one-cycle MemReady/MemError pulse.
module data_memory_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemError
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [3:0]    count_r;
  logic [3:0]    count_next_s;
  logic          armed_r;
  logic [AW-1:0] index_r;
  logic [31:0]   wdata_r;
  logic          write_r;
  logic [31:0]   rdata_r;
  logic          ready_r;
  logic          error_r;
  logic [31:0]   mem_r [DEPTH];
  logic          request_s;
  logic          accept_s;
  logic          invalid_s;

  // Request qualification: acceptance needs a fresh strobe (armed) while idle.
  always_comb begin
    request_s = MemRead | MemWrite;
    accept_s  = (state_r == IDLE) && armed_r && request_s;
    invalid_s = (MemRead & MemWrite) | (Address[1:0] != 2'b00) |
                ({2'b00, Address[31:2]} >= DEPTH_W);
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (invalid_s) begin
            state_next_s = DONE;
          end else if (HAS_WAIT) begin
            state_next_s = WAIT;
            count_next_s = WAIT_LOAD;
          end else begin
            state_next_s = ACCESS;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (count_r == 4'd0) begin
          state_next_s = ACCESS;
        end else begin
          count_next_s = count_r - 4'd1;
        end
      end
      ACCESS:  state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Control, request latches and registered outputs; Reset overrides every transition.
  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_r <= IDLE;
      count_r <= 4'd0;
      armed_r <= 1'b1;
      index_r <= {AW{1'b0}};
      wdata_r <= 32'd0;
      write_r <= 1'b0;
      rdata_r <= 32'd0;
      ready_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      ready_r <= (state_next_s == DONE);
      error_r <= accept_s & invalid_s;
      if (accept_s) begin
        armed_r <= 1'b0;
        index_r <= Address[AW+1:2];
        wdata_r <= WriteData;
        write_r <= MemWrite;
      end else if (!request_s) begin
        armed_r <= 1'b1;
      end
      if ((state_r == ACCESS) && !write_r) begin
        rdata_r <= mem_r[index_r];
      end
    end
  end

  // Storage array keeps its contents across reset; a reset edge suppresses a pending store.
  always_ff @(posedge clock) begin
    if (Reset && (state_r == ACCESS) && write_r) begin
      mem_r[index_r] <= wdata_r;
    end
  end

  assign ReadData = rdata_r;
  assign MemReady = ready_r;
  assign MemError = error_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: three instances (WAIT_CYCLES 1, 0, 15)
// driven one at a time, checked against an array-based reference memory.
module tb_data_memory_responder;

  localparam int          NI      = 3;
  localparam int          DEPTH   = 64;
  localparam int          NPRE    = 16;
  localparam logic [31:0] DEPTH_W = 32'd64;

  typedef struct {
    int          inst;
    logic        err;
    logic        is_load;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clock;
  logic        Reset;
  logic        rd    [NI];
  logic        wr    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic        ready [NI];
  logic        err   [NI];

  int          wc [NI] = '{1, 0, 15};
  logic [31:0] mdl  [NI][DEPTH];
  logic [31:0] hold [NI];
  exp_t        sbq [$];
  exp_t        mon_e;
  int          cyc    = 0;
  logic        rst_q  = 1'b0;
  logic        live   = 1'b0;
  int          n_done = 0;
  int          n_vec  = 0;
  int          n_err  = 0;

  data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u0 (
    .clock(clock), .Reset(Reset), .MemRead(rd[0]), .MemWrite(wr[0]), .Address(addr[0]),
    .WriteData(wdata[0]), .ReadData(rdata[0]), .MemReady(ready[0]), .MemError(err[0]));
  data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u1 (
    .clock(clock), .Reset(Reset), .MemRead(rd[1]), .MemWrite(wr[1]), .Address(addr[1]),
    .WriteData(wdata[1]), .ReadData(rdata[1]), .MemReady(ready[1]), .MemError(err[1]));
  data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(15)) u2 (
    .clock(clock), .Reset(Reset), .MemRead(rd[2]), .MemWrite(wr[2]), .Address(addr[2]),
    .WriteData(wdata[2]), .ReadData(rdata[2]), .MemReady(ready[2]), .MemError(err[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter and reset observation.
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= !Reset;
    if (!Reset) live <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever any instance pulses MemReady.
  always @(negedge clock) begin
    if (live) begin
      for (int i = 0; i < NI; i++) begin
        if (rst_q) begin
          hold[i] = 32'd0;
          chk("reset_ready", {31'd0, ready[i]}, 32'd0);
        end
        if (ready[i] === 1'b1) begin
          if (sbq.size() == 0) begin
            chk($sformatf("unexpected_ready_u%0d", i), 32'd1, 32'd0);
          end else begin
            mon_e = sbq.pop_front();
            chk("ready_instance", i, mon_e.inst);
            chk("latency_edge", cyc, mon_e.due);
            chk("mem_error", {31'd0, err[i]}, {31'd0, mon_e.err});
            if (mon_e.is_load && !mon_e.err) hold[i] = mon_e.data;
            chk("read_data", rdata[i], hold[i]);
            n_done++;
          end
        end else begin
          chk("error_without_ready", {31'd0, err[i]}, 32'd0);
          chk("read_data_hold", rdata[i], hold[i]);
        end
      end
    end
  end

  task automatic request(input int i, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int linger);
    exp_t e;
    logic bad;
    int   start;
    bit   got;
    bad       = (r & w) | (a[1:0] != 2'b00) | ({2'b00, a[31:2]} >= DEPTH_W);
    e.inst    = i;
    e.err     = bad;
    e.is_load = r & ~w;
    e.data    = 32'd0;
    e.due     = cyc + 1 + (bad ? 0 : wc[i] + 1);
    if (!bad) begin
      if (w) mdl[i][a[7:2]] = d;
      else   e.data = mdl[i][a[7:2]];
    end
    sbq.push_back(e);
    start    = n_done;
    rd[i]    = r;
    wr[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    got      = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock); #1;
      addr[i]  = $urandom;
      wdata[i] = $urandom;
      got      = (n_done != start);
    end
    if (!got) begin
      chk("ready_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
    repeat (linger) begin
      @(negedge clock); #1;
    end
    rd[i] = 1'b0;
    wr[i] = 1'b0;
    @(negedge clock); #1;
  endtask

  task automatic reset_mid_store();
    wr[0]    = 1'b1;
    addr[0]  = 32'h0000_0020;
    wdata[0] = 32'h1234_5678;
    @(negedge clock); #1;
    Reset = 1'b0;
    wr[0] = 1'b0;
    @(negedge clock); #1;
    Reset = 1'b1;
    @(negedge clock); #1;
  endtask

  initial begin
    int          sel;
    int          asel;
    logic        r;
    logic        w;
    logic [31:0] a;
    Reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0; hold[i] = 32'd0;
    end
    repeat (3) @(negedge clock);
    #1 Reset = 1'b1;
    @(negedge clock); #1;

    request(0, 1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 0);
    request(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    request(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         2);
    request(0, 1'b0, 1'b1, 32'h0000_0012, 32'h0BAD_F00D, 0);
    request(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 0);
    request(0, 1'b1, 1'b1, 32'h0000_0010, 32'h0,         3);
    request(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         0);
    reset_mid_store();
    request(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         0);
    request(1, 1'b1, 1'b1, 32'h0000_0000, 32'h0,         0);
    request(2, 1'b0, 1'b1, 32'h0000_0003, 32'h0,         0);

    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < NPRE; k++) request(i, 1'b0, 1'b1, k * 4, $urandom, 0);
    end

    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 30; n++) begin
        sel  = $urandom_range(0, 9);
        asel = $urandom_range(0, 7);
        r    = (sel < 4) || (sel == 8);
        w    = !(sel < 4);
        a    = 32'($urandom_range(0, NPRE - 1)) << 2;
        if (asel == 0) a = a | 32'($urandom_range(1, 3));
        if (asel == 1) a = $urandom | 32'h0000_0100;
        request(i, r, w, a, $urandom, $urandom_range(0, 2));
      end
    end

    repeat (5) @(negedge clock);
    #1 chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH SHALL be: default 64; number of 32-bit words, power of two, 2..1024.
REQ-002 Parameter WAIT_CYCLES SHALL be: default 1; wait states before access, 0..15.
REQ-003 Port clock SHALL be: input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port Reset SHALL be: input, 1, synchronous active-low reset (0 = reset, sampled on rising edge of clock).
REQ-005 Port MemRead SHALL be: input, 1, load request strobe from the control unit.
REQ-006 Port MemWrite SHALL be: input, 1, store request strobe from the control unit.
REQ-007 Port Address SHALL be: input, 32, byte address from the ALU result.
REQ-008 Port WriteData SHALL be: input, 32, store data.
REQ-009 Port ReadData SHALL be: output, 32, load data; valid while MemReady=1 and MemError=0.
REQ-010 Port MemReady SHALL be: output, 1, one-cycle completion pulse.
REQ-011 Port MemError SHALL be: output, 1, qualifies MemReady; 1 = request rejected.

Function
REQ-012 FSM SHALL have states IDLE, WAIT, ACCESS and DONE, and SHALL sit in IDLE after reset.
REQ-013 Internal flag armed SHALL be set in any cycle with MemRead=0 and MemWrite=0, and cleared on acceptance.
REQ-014 A request SHALL be accepted in IDLE only when armed=1 and (MemRead|MemWrite)=1; a strobe held across DONE SHALL NOT be re-accepted until it drops.
REQ-015 On acceptance, Address, WriteData and the request type SHALL be latched; later input changes SHALL be ignored until DONE.
REQ-016 Request validity rules:
- invalid if MemRead=1 and MemWrite=1
- invalid if Address[1:0]!=0
- invalid if word index Address[31:2] >= DEPTH
REQ-017 Invalid request: IDLE->DONE on the accepting edge with MemError=1; no memory or ReadData change.
REQ-018 Valid request transitions:
- IDLE->WAIT if WAIT_CYCLES>0, else IDLE->ACCESS
- WAIT: 4-bit counter loaded with WAIT_CYCLES-1 on entry, decremented each cycle; WAIT->ACCESS when counter=0
REQ-019 ACCESS->DONE unconditionally; the array write (store) or ReadData load (load) SHALL occur on that edge.
REQ-020 DONE SHALL assert MemReady=1 for exactly one cycle, then DONE->IDLE.
REQ-021 Valid-request latency: MemReady high in the cycle after WAIT_CYCLES+2 rising edges counted from and including the accepting edge; invalid-request latency is 1 edge.
REQ-022 MemError SHALL be 0 whenever MemReady=0; ReadData SHALL hold its value except on a successful load.
REQ-023 Stores SHALL write the full 32-bit word; no byte enables.
REQ-024 Outputs SHALL be registered (Moore); no combinational path from inputs to outputs.

Reset
REQ-025 Reset=0 at a rising edge SHALL force state=IDLE, counter=0, armed=1, ReadData=0, MemReady=0, MemError=0.
REQ-026 Reset SHALL override every transition; a store in WAIT or ACCESS at a reset edge SHALL NOT write the array.
REQ-027 The array SHALL NOT be cleared by reset; contents are preserved across reset and undefined at power-up.

Verification
REQ-028 Store, WAIT_CYCLES=1: reset, then MemWrite=1, Address=0x10, WriteData=0xDEADBEEF -> MemReady=1, MemError=0 in the cycle after the 3rd edge including acceptance; word 4 = 0xDEADBEEF.
REQ-029 Load: drop strobes one cycle, then MemRead=1, Address=0x10 -> ReadData=0xDEADBEEF with MemReady=1, MemError=0; ReadData holds after.
REQ-030 Misaligned and out-of-range requests:
- MemWrite=1, Address=0x12 -> MemReady=1, MemError=1 one edge after acceptance; word 4 still 0xDEADBEEF
- Address=0x100, DEPTH=64 -> same error response
REQ-031 Both strobes, then re-arm:
- MemRead=MemWrite=1 -> error response
- strobe held high after DONE -> no second MemReady until strobes drop for >=1 cycle
REQ-032 Reset mid-store: MemWrite to 0x20 with 0x12345678, Reset=0 while in WAIT -> all outputs 0, state IDLE; a later load of 0x20 does not return 0x12345678 (pre-store value 0xA5A5A5A5 retained).
REQ-033 WAIT_CYCLES=0 and WAIT_CYCLES=15: load -> MemReady after 2 and 17 edges respectively.
